// File: rtl/hazard_ctrl.sv
// Pipeline hazard / SRAM-wait sequencer: load-use and RAW stalls, branch flush, MEM wait FSM.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward_en,
  input  logic [ADDR_W-1:0] src1_ID,
  input  logic [ADDR_W-1:0] src2_ID,
  input  logic              two_src_ID,
  input  logic [ADDR_W-1:0] dest_EXE,
  input  logic              WB_EN_EXE,
  input  logic              MEM_R_EN_EXE,
  input  logic [ADDR_W-1:0] dest_MEM,
  input  logic              WB_EN_MEM,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              branch_taken_EXE,
  output logic              freeze_pc,
  output logic              freeze_IF_ID,
  output logic              freeze_all,
  output logic              bubble_ID_EXE,
  output logic              flush_IF_ID,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            mem_stall;
  logic            hit_exe, hit_mem, hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
    end
  end

  // Timeout fires on the TIMEOUT-th consecutive WAIT cycle without ready.
  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    unique case (state)
      IDLE: begin
        if (mem_req) begin
          state_nxt  = WAIT;
          to_cnt_nxt = '0;
        end
      end
      WAIT: begin
        if (mem_ready)
          state_nxt = DONE;
        else if (to_cnt == TO_W'(TIMEOUT - 1))
          state_nxt = ERR;
        else
          to_cnt_nxt = to_cnt + TO_W'(1);
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_stall = ((state == IDLE) && mem_req) || (state == WAIT);

  assign hit_exe = (src1_ID == dest_EXE) || (two_src_ID && (src2_ID == dest_EXE));
  assign hit_mem = (src1_ID == dest_MEM) || (two_src_ID && (src2_ID == dest_MEM));

  always_comb begin
    if (forward_en)
      hazard = MEM_R_EN_EXE && WB_EN_EXE && hit_exe;
    else
      hazard = (WB_EN_EXE && hit_exe) || (WB_EN_MEM && hit_mem);
  end

  // Outputs are forced low while reset is held, independent of the data inputs.
  always_comb begin
    freeze_pc     = 1'b0;
    freeze_IF_ID  = 1'b0;
    freeze_all    = 1'b0;
    bubble_ID_EXE = 1'b0;
    flush_IF_ID   = 1'b0;
    mem_err       = rst && (state == ERR);
    if (rst) begin
      if (mem_stall) begin
        freeze_pc    = 1'b1;
        freeze_IF_ID = 1'b1;
        freeze_all   = 1'b1;
      end else if (branch_taken_EXE) begin
        flush_IF_ID   = 1'b1;
        bubble_ID_EXE = 1'b1;
      end else if (hazard) begin
        freeze_pc     = 1'b1;
        freeze_IF_ID  = 1'b1;
        bubble_ID_EXE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_cnt <= '0;
    else if (freeze_pc && (perf_cnt != '1))
      perf_cnt <= perf_cnt + CNT_W'(1);
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the combinational priority logic,
// hand sequences for SRAM wait, timeout, branch-under-stall and reset.
module tb_hazard_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned EXP_PERF = 5;
`else
  localparam int unsigned EXP_PERF = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              forward_en, two_src_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM;
  logic [ADDR_W-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic              mem_req, mem_ready, branch_taken_EXE;
  logic              freeze_pc, freeze_IF_ID, freeze_all, bubble_ID_EXE, flush_IF_ID, mem_err;
  logic [CNT_W-1:0]  stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(15), .TO_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
    .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
    .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken_EXE(branch_taken_EXE),
    .freeze_pc(freeze_pc), .freeze_IF_ID(freeze_IF_ID), .freeze_all(freeze_all),
    .bubble_ID_EXE(bubble_ID_EXE), .flush_IF_ID(flush_IF_ID),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Packed as {freeze_pc, freeze_IF_ID, freeze_all, bubble_ID_EXE, flush_IF_ID}
  wire [4:0] outs = {freeze_pc, freeze_IF_ID, freeze_all, bubble_ID_EXE, flush_IF_ID};

  typedef struct {
    string      name;
    logic       fwd;
    logic [3:0] s1, s2;
    logic       two;
    logic [3:0] d_exe;
    logic       wb_exe, mr_exe;
    logic [3:0] d_mem;
    logic       wb_mem, br;
    logic [4:0] exp_o;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    forward_en = 1'b0; src1_ID = '0; src2_ID = '0; two_src_ID = 1'b0;
    dest_EXE = '0; WB_EN_EXE = 1'b0; MEM_R_EN_EXE = 1'b0;
    dest_MEM = '0; WB_EN_MEM = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; branch_taken_EXE = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    int stall_n;

    vecs[0]  = '{"load_use_src1",    1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 5'b11010};
    vecs[1]  = '{"no_load_fwd",      1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 5'b00000};
    vecs[2]  = '{"load_use_src2",    1, 1, 6, 1, 6, 1, 1, 0, 0, 0, 5'b11010};
    vecs[3]  = '{"load_src2_unused", 1, 1, 6, 0, 6, 1, 1, 0, 0, 0, 5'b00000};
    vecs[4]  = '{"raw_mem_src2",     0, 1, 5, 1, 0, 0, 0, 5, 1, 0, 5'b11010};
    vecs[5]  = '{"raw_mem_one_src",  0, 1, 5, 0, 0, 0, 0, 5, 1, 0, 5'b00000};
    vecs[6]  = '{"raw_exe_nofwd",    0, 7, 0, 0, 7, 1, 0, 2, 0, 0, 5'b11010};
    vecs[7]  = '{"mem_hit_fwd",      1, 5, 0, 0, 9, 1, 1, 5, 1, 0, 5'b00000};
    vecs[8]  = '{"r0_load_use",      1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 5'b11010};
    vecs[9]  = '{"branch_over_haz",  1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 5'b00011};
    vecs[10] = '{"branch_alone",     0, 1, 2, 1, 4, 0, 0, 8, 0, 1, 5'b00011};
    vecs[11] = '{"mem_no_wb",        0, 5, 0, 0, 9, 0, 0, 5, 0, 0, 5'b00000};
    vecs[12] = '{"load_no_wb",       1, 3, 0, 0, 3, 0, 1, 0, 0, 0, 5'b00000};

    clear_inputs();
    rst = 1'b0;
    #1;
    chk("reset_outs", 32'(outs), 32'h0);
    chk("reset_err", 32'(mem_err), 32'h0);
    chk("reset_perf", 32'(stall_cycles), 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b1;

    // SRAM access: ready on the third WAIT cycle
    stall_n = 0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      mem_req   = (i < 4);
      mem_ready = (i == 3);
      #1;
      if (freeze_all) stall_n++;
      if (i < 4) chk($sformatf("sram_stall_%0d", i), 32'(outs), 32'h1C);
      else       chk($sformatf("sram_free_%0d", i), 32'(outs), 32'h0);
    end
    chk("sram_stall_len", 32'(stall_n), 32'd4);
    chk("sram_err", 32'(mem_err), 32'h0);

    // Load-use stalls exactly one cycle: the bubble clears EXE next cycle
    next_cycle();
    clear_inputs();
    forward_en = 1; MEM_R_EN_EXE = 1; WB_EN_EXE = 1; dest_EXE = 3; src1_ID = 3;
    #1 chk("lu_cycle0", 32'(outs), 32'h1A);
    next_cycle();
    MEM_R_EN_EXE = 0; WB_EN_EXE = 0; dest_EXE = 0;
    #1 chk("lu_cycle1", 32'(outs), 32'h0);
    chk("perf_after_5", 32'(stall_cycles), 32'(EXP_PERF));

    for (int i = 0; i < 13; i++) begin
      next_cycle();
      clear_inputs();
      forward_en = vecs[i].fwd; src1_ID = vecs[i].s1; src2_ID = vecs[i].s2;
      two_src_ID = vecs[i].two; dest_EXE = vecs[i].d_exe; WB_EN_EXE = vecs[i].wb_exe;
      MEM_R_EN_EXE = vecs[i].mr_exe; dest_MEM = vecs[i].d_mem; WB_EN_MEM = vecs[i].wb_mem;
      branch_taken_EXE = vecs[i].br;
      #1 chk(vecs[i].name, 32'(outs), 32'(vecs[i].exp_o));
    end

    // Branch held during an SRAM stall is only honoured on the DONE cycle
    next_cycle();
    clear_inputs();
    branch_taken_EXE = 1; mem_req = 1;
    #1 chk("br_stall_idle", 32'(outs), 32'h1C);
    next_cycle();
    mem_ready = 1;
    #1 chk("br_stall_wait", 32'(outs), 32'h1C);
    next_cycle();
    mem_req = 0; mem_ready = 0;
    #1 chk("br_done_flush", 32'(outs), 32'h03);
    next_cycle();
    clear_inputs();
    #1 chk("br_after", 32'(outs), 32'h0);

    // Timeout: 1 IDLE request cycle + 15 WAIT cycles, then ERR
    stall_n = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      mem_req = 1;
      #1;
      if (!freeze_all) break;
      stall_n++;
    end
    chk("to_stall_len", 32'(stall_n), 32'd16);
    chk("to_err_set", 32'(mem_err), 32'h1);
    chk("to_err_outs", 32'(outs), 32'h0);
    next_cycle();
    mem_ready = 1;
    #1 chk("to_err_sticky", 32'({mem_err, outs}), 32'h20);
    next_cycle();
    rst = 0; branch_taken_EXE = 1;
    #1 chk("to_rst_outs", 32'({mem_err, outs}), 32'h0);
    next_cycle();
    rst = 1;
    clear_inputs();
    #1 chk("to_rst_clear", 32'({mem_err, outs}), 32'h0);

    // Asynchronous reset in the middle of WAIT
    next_cycle();
    mem_req = 1;
    next_cycle();
    #1 chk("mw_in_wait", 32'(freeze_all), 32'h1);
    #2 rst = 0;
    #1 chk("mw_rst_outs", 32'({mem_err, outs}), 32'h0);
    chk("mw_rst_perf", 32'(stall_cycles), 32'h0);
    next_cycle();
    next_cycle();
    rst = 1; mem_req = 0;
    #1 chk("mw_idle_after", 32'(outs), 32'h0);
    next_cycle();
    mem_req = 1;
    #1 chk("mw_new_req", 32'(outs), 32'h1C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Detects load-use and RAW hazards between ID and the EXE/MEM stages, drives freeze/bubble/flush of the IF/ID/EXE registers, and sequences multi-cycle SRAM accesses in MEM through a wait FSM.
- Complements the EXE-stage forwarding unit: whatever forwarding cannot resolve, this block stalls.

Parameters:
- ADDR_W, 4, register-file address width (matches REG_FILE_ADDR_LEN).
- TIMEOUT, 15, max SRAM wait cycles before error; 1..(2^TO_W)-1.
- TO_W, 4, width of timeout counter.
- CNT_W, 16, width of stall performance counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- forward_en  in  1  1 = forwarding unit active.
- src1_ID  in  ADDR_W  ID-stage source 1.
- src2_ID  in  ADDR_W  ID-stage source 2.
- two_src_ID  in  1  ID instruction reads src2.
- dest_EXE  in  ADDR_W  EXE-stage destination.
- WB_EN_EXE  in  1  EXE writes back.
- MEM_R_EN_EXE  in  1  EXE instruction is a load.
- dest_MEM  in  ADDR_W  MEM-stage destination.
- WB_EN_MEM  in  1  MEM writes back.
- mem_req  in  1  MEM stage performs SRAM read/write this cycle.
- mem_ready  in  1  SRAM access complete.
- branch_taken_EXE  in  1  taken branch resolved in EXE.
- freeze_pc  out  1  hold PC.
- freeze_IF_ID  out  1  hold IF/ID register.
- freeze_all  out  1  hold ID/EXE, EXE/MEM, MEM/WB registers.
- bubble_ID_EXE  out  1  load NOP into ID/EXE.
- flush_IF_ID  out  1  clear IF/ID.
- mem_err  out  1  sticky SRAM timeout flag.
- stall_cycles  out  CNT_W  stall performance counter.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, timeout count=0, mem_err=0, stall_cycles=0; all outputs 0 while rst=0.
- Data hazard (combinational), m1 = src1_ID match, m2 = two_src_ID && src2_ID match:
  - forward_en=1: hazard = MEM_R_EN_EXE && WB_EN_EXE && (m1||m2 vs dest_EXE).
  - forward_en=0: hazard = (WB_EN_EXE && (m1||m2 vs dest_EXE)) || (WB_EN_MEM && (m1||m2 vs dest_MEM)).
- SRAM FSM, states IDLE, WAIT, DONE, ERR:
  - IDLE: mem_req=1 -> WAIT, count=0.
  - WAIT: mem_ready=1 -> DONE; else count++; count==TIMEOUT-1 without ready -> ERR.
  - DONE: one cycle, -> IDLE unconditionally.
  - ERR: mem_err=1, mem_stall=0, stays until reset.
  - mem_ready ignored outside WAIT.
- mem_stall = (IDLE && mem_req) || WAIT. Access of N ready-cycles costs N+1 stall cycles; DONE cycle lets the pipeline advance.
- Output priority, highest first:
  - mem_stall: freeze_pc=freeze_IF_ID=freeze_all=1, bubble=0, flush=0. Branch/hazard deferred; frozen EXE keeps branch_taken_EXE valid for the release cycle.
  - branch_taken_EXE: flush_IF_ID=1, bubble_ID_EXE=1, no freezes. Flush overrides a simultaneous data hazard.
  - hazard: freeze_pc=freeze_IF_ID=1, bubble_ID_EXE=1. freeze_all=0.
  - otherwise all 0.
- Register 0 is not special-cased; a match on r0 still stalls.
- Reset mid-WAIT returns FSM to IDLE immediately and clears the counter.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments each cycle freeze_pc=1, saturating at all-ones; cleared only by reset.
- Undefined: stall_cycles tied to 0, no counter flops.

Test Plan:
- Load-use, forward_en=1: MEM_R_EN_EXE=1, WB_EN_EXE=1, dest_EXE=3, src1_ID=3 -> freeze_pc=freeze_IF_ID=bubble_ID_EXE=1 for exactly 1 cycle, freeze_all=0.
- Non-load RAW, forward_en=0: WB_EN_MEM=1, dest_MEM=5, two_src_ID=1, src2_ID=5 -> stall asserted. Same with two_src_ID=0 -> no stall.
- SRAM: mem_req=1, mem_ready high on 3rd WAIT cycle -> freeze_all high 4 cycles, FSM IDLE->WAIT->DONE->IDLE, mem_err=0.
- Timeout, TIMEOUT=15: mem_req=1, mem_ready=0 -> ERR after 15 WAIT cycles, mem_err=1 sticky, freezes drop; rst pulse clears.
- Branch during mem stall: branch_taken_EXE=1 with mem_req=1 -> no flush while stalled; flush_IF_ID=bubble_ID_EXE=1 on DONE cycle.
- Perf counter (macro defined): 4-cycle SRAM stall + 1 load-use -> stall_cycles=5; async reset mid-WAIT -> counter 0, FSM IDLE.
